// File: rtl/cp0_unit.sv
// System coprocessor 0 for the M stage: SR, Cause, EPC and PRId, mtc0/mfc0
// access, interrupt/exception request generation and the eret return address.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h0000_0700
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] CP0Out,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // Only the architecturally defined fields are stored; every other bit
    // of SR and Cause is a constant zero on read.
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_read;
    logic [31:0] cause_read;

    // An interrupt pre-empts a concurrent instruction exception; EXL blocks both.
    assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
    assign Req     = int_req | exc_req;

    assign sr_read    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_read = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};

    // Forward a same-cycle mtc0 EPC so an immediately following eret sees it.
    assign EPCOut = (en && CP0Add == ADDR_EPC) ? CP0In : epc_q;

    // Next-state: exception entry has absolute priority over mtc0 and eret.
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_d      = HWInt;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (Req) begin
            exl_d     = 1'b1;
            exccode_d = int_req ? 5'd0 : ExcCodeIn;
            bd_d      = BDIn;
            epc_d     = BDIn ? (VPC - 32'd4) : VPC;
        end else begin
            if (en && CP0Add == ADDR_SR) begin
                im_d  = CP0In[15:10];
                exl_d = CP0In[1];
                ie_d  = CP0In[0];
            end
            if (en && CP0Add == ADDR_EPC) begin
                epc_d = CP0In;
            end
            // eret overrides only the EXL bit of a coincident SR write.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    // mfc0 read multiplexer.
    always_comb begin
        CP0Out = 32'd0;
        case (CP0Add)
            ADDR_SR:    CP0Out = sr_read;
            ADDR_CAUSE: CP0Out = cause_read;
            ADDR_EPC:   CP0Out = epc_q;
            ADDR_PRID:  CP0Out = PRID;
            default:    CP0Out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized
// traffic compared against a word-level model of the CP0 registers.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] CP0Out;
    logic [31:0] EPCOut;
    logic        Req;

    int errors = 0;
    int checks = 0;

    // Reference state held as whole 32-bit register words.
    logic [31:0] m_sr, m_cause, m_epc;

    cp0_unit #(.PRID(32'h0000_0700)) dut (
        .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
        .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .CP0Out(CP0Out), .EPCOut(EPCOut), .Req(Req)
    );

    always #5 clk = ~clk;

    function automatic logic m_int_req();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int_req() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_0700;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_epcout();
        return (en && CP0Add == 5'd14) ? CP0In : m_epc;
    endfunction

    // Advance one clock: evaluate the model from the pre-edge inputs, then
    // land 1 time unit after the edge so inputs can be changed safely.
    task automatic step();
        logic [31:0] sr_n, cause_n, epc_n;
        sr_n = m_sr; cause_n = m_cause; epc_n = m_epc;
        if (reset) begin
            sr_n = 0; cause_n = 0; epc_n = 0;
        end else begin
            cause_n = (cause_n & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
            if (m_req()) begin
                sr_n    = sr_n | 32'h2;
                cause_n = (cause_n & ~32'h8000_007C) | ({31'd0, BDIn} << 31)
                        | (m_int_req() ? 32'd0 : ({27'd0, ExcCodeIn} << 2));
                epc_n   = BDIn ? VPC - 32'd4 : VPC;
            end else begin
                if (en && CP0Add == 5'd12) sr_n = CP0In & 32'h0000_FC03;
                if (en && CP0Add == 5'd14) epc_n = CP0In;
                if (EXLClr) sr_n = sr_n & ~32'h2;
            end
        end
        @(posedge clk);
        m_sr = sr_n; m_cause = cause_n; m_epc = epc_n;
        #1;
    endtask

    task automatic idle();
        reset = 0; en = 0; CP0Add = 5'd0; CP0In = 0; VPC = 0; BDIn = 0;
        ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
    endtask

    task automatic do_reset();
        idle(); reset = 1; step(); reset = 0;
    endtask

    task automatic mtc0_sr(input logic [31:0] v);
        en = 1; CP0Add = 5'd12; CP0In = v; step(); en = 0; CP0In = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        #1;
        checks++; if (Req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", Req); end
        for (int a = 12; a <= 14; a++) begin
            CP0Add = a[4:0]; #1; rd = CP0Out;
            checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", a, rd); end
        end
        checks++; if (EPCOut !== 32'd0) begin errors++; $display("FAIL reset_epcout got=%h exp=0", EPCOut); end
        $display("test_reset done");
    endtask

    task automatic test_interrupt();
        do_reset();
        mtc0_sr(32'h0000_0401);
        HWInt = 6'b000001; VPC = 32'h0000_3010; BDIn = 0; #1;
        checks++; if (Req !== 1'b1) begin errors++; $display("FAIL int_req got=%b exp=1", Req); end
        step(); #1;
        checks++; if (Req !== 1'b0) begin errors++; $display("FAIL int_exl_mask got=%b exp=0", Req); end
        CP0Add = 5'd12; #1;
        checks++; if (CP0Out !== 32'h0000_0403) begin errors++; $display("FAIL int_sr got=%h exp=00000403", CP0Out); end
        CP0Add = 5'd13; #1;
        checks++; if (CP0Out !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got=%h exp=00000400", CP0Out); end
        CP0Add = 5'd14; #1;
        checks++; if (CP0Out !== 32'h0000_3010) begin errors++; $display("FAIL int_epc got=%h exp=00003010", CP0Out); end
        $display("test_interrupt done");
    endtask

    task automatic test_delay_slot();
        do_reset();
        mtc0_sr(32'h0000_0001);
        ExcCodeIn = 5'd12; BDIn = 1; VPC = 32'h0000_3024; #1;
        checks++; if (Req !== 1'b1) begin errors++; $display("FAIL bd_req got=%b exp=1", Req); end
        step(); ExcCodeIn = 0; BDIn = 0;
        CP0Add = 5'd13; #1;
        checks++; if (CP0Out !== 32'h8000_0030) begin errors++; $display("FAIL bd_cause got=%h exp=80000030", CP0Out); end
        CP0Add = 5'd14; #1;
        checks++; if (CP0Out !== 32'h0000_3020) begin errors++; $display("FAIL bd_epc got=%h exp=00003020", CP0Out); end
        CP0Add = 5'd12; #1;
        checks++; if (CP0Out !== 32'h0000_0003) begin errors++; $display("FAIL bd_sr got=%h exp=00000003", CP0Out); end
        $display("test_delay_slot done");
    endtask

    task automatic test_priority();
        do_reset();
        mtc0_sr(32'h0000_0801);
        HWInt = 6'b000010; ExcCodeIn = 5'd10; VPC = 32'h0000_3100; #1;
        checks++; if (Req !== 1'b1) begin errors++; $display("FAIL prio_req got=%b exp=1", Req); end
        step(); ExcCodeIn = 0;
        CP0Add = 5'd13; #1;
        checks++; if (CP0Out !== 32'h0000_0800) begin errors++; $display("FAIL prio_cause got=%h exp=00000800", CP0Out); end
        $display("test_priority done");
    endtask

    task automatic test_collision_eret();
        do_reset();
        mtc0_sr(32'h0000_0001);
        ExcCodeIn = 5'd4; VPC = 32'h0000_5000; en = 1; CP0Add = 5'd14; CP0In = 32'hDEAD_BEE0; #1;
        checks++; if (Req !== 1'b1) begin errors++; $display("FAIL coll_req got=%b exp=1", Req); end
        step(); idle();
        CP0Add = 5'd14; #1;
        checks++; if (CP0Out !== 32'h0000_5000) begin errors++; $display("FAIL coll_epc got=%h exp=00005000", CP0Out); end
        EXLClr = 1; #1;
        checks++; if (Req !== 1'b0) begin errors++; $display("FAIL eret_req got=%b exp=0", Req); end
        step(); EXLClr = 0;
        CP0Add = 5'd12; #1;
        checks++; if (CP0Out !== 32'h0000_0001) begin errors++; $display("FAIL eret_sr got=%h exp=00000001", CP0Out); end
        $display("test_collision_eret done");
    endtask

    task automatic test_bypass();
        en = 1; CP0Add = 5'd14; CP0In = 32'h0000_4000; #1;
        checks++; if (EPCOut !== 32'h0000_4000) begin errors++; $display("FAIL byp_epcout got=%h exp=00004000", EPCOut); end
        checks++; if (CP0Out !== 32'h0000_5000) begin errors++; $display("FAIL byp_old_epc got=%h exp=00005000", CP0Out); end
        step(); idle();
        CP0Add = 5'd14; #1;
        checks++; if (CP0Out !== 32'h0000_4000) begin errors++; $display("FAIL byp_new_epc got=%h exp=00004000", CP0Out); end
        CP0Add = 5'd15; #1;
        checks++; if (CP0Out !== 32'h0000_0700) begin errors++; $display("FAIL prid got=%h exp=00000700", CP0Out); end
        CP0Add = 5'd16; #1;
        checks++; if (CP0Out !== 32'd0) begin errors++; $display("FAIL unmapped got=%h exp=0", CP0Out); end
        $display("test_bypass done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        mtc0_sr(32'h0000_FC01);
        HWInt = 6'h3F; VPC = 32'h0000_6000; en = 1; CP0Add = 5'd14; CP0In = 32'h1234_5678; EXLClr = 1; #1;
        checks++; if (Req !== 1'b1) begin errors++; $display("FAIL rmid_req_before got=%b exp=1", Req); end
        reset = 1; step(); reset = 0; en = 0; EXLClr = 0;
        #1;
        checks++; if (Req !== 1'b0) begin errors++; $display("FAIL rmid_req got=%b exp=0", Req); end
        for (int a = 12; a <= 14; a++) begin
            CP0Add = a[4:0]; #1;
            checks++; if (CP0Out !== 32'd0) begin errors++; $display("FAIL rmid_reg%0d got=%h exp=0", a, CP0Out); end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [4:0] addrs [5];
        addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14; addrs[3] = 5'd15; addrs[4] = 5'd0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 39) == 0);
            en        = ($urandom_range(0, 2) == 0);
            CP0Add    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 4)];
            CP0In     = $urandom;
            VPC       = $urandom;
            BDIn      = 1'($urandom);
            ExcCodeIn = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            HWInt     = 6'($urandom);
            EXLClr    = ($urandom_range(0, 5) == 0);
            #1;
            checks++; if (Req !== m_req()) begin errors++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, Req, m_req()); end
            checks++; if (CP0Out !== m_read(CP0Add)) begin errors++; $display("FAIL rnd_cp0out n=%0d addr=%0d got=%h exp=%h", n, CP0Add, CP0Out, m_read(CP0Add)); end
            checks++; if (EPCOut !== m_epcout()) begin errors++; $display("FAIL rnd_epcout n=%0d got=%h exp=%h", n, EPCOut, m_epcout()); end
            step();
        end
        idle();
        $display("test_random done");
    endtask

    initial begin
        m_sr = 0; m_cause = 0; m_epc = 0;
        idle();
        test_reset();
        test_interrupt();
        test_delay_slot();
        test_priority();
        test_collision_eret();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
